pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 71, payload width in bits (RegW 1 + ResultSrc 1 + ALU 32 + mem 32 + rd 5).
REQ-002 Parameter DEPTH, default 1, number of register stages; legal range 1..4; other values SHALL be rejected at elaboration.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream payload valid.
REQ-006 in_ready  output  1  block accepts payload this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 flush  input  1  synchronous kill of all in-flight payloads.
REQ-009 out_valid  output  1  last stage holds a valid payload.
REQ-010 out_ready  input  1  downstream accepts payload this cycle.
REQ-011 out_data  output  DATA_W  last-stage payload.
REQ-012 occ  output  3  number of stages currently valid, 0..DEPTH.

Function
REQ-013 Each stage k (0..DEPTH-1) SHALL hold valid_k and data_k; stage 0 fed by in_*, stage DEPTH-1 drives out_valid/out_data.
REQ-014 Stage k SHALL be able to load when valid_k=0 or stage k+1 unloads this cycle; last stage unloads when out_valid && out_ready.
REQ-015 in_ready SHALL equal stage 0 load condition AND NOT flush (combinational ready chain, no skid register).
REQ-016 Transfer in (in_valid && in_ready) SHALL write in_data to data_0 and set valid_0 at the next edge.
REQ-017 Stage k+1 SHALL capture data_k/valid_k when it loads; stage k clears valid_k if unloaded and not reloaded in the same cycle.
REQ-018 Latency in->out SHALL be exactly DEPTH cycles with out_ready held high; sustained throughput one payload per cycle.
REQ-019 Data registers SHALL update only on a load; with out_valid=0 out_data holds its last value.
REQ-020 Payload order SHALL be preserved; no payload duplicated or dropped except by flush.
REQ-021 Full (occ=DEPTH) with out_ready=0: in_ready=0, all stages hold; out_data stable while out_valid && !out_ready.
REQ-022 Full with out_ready=1 and in_valid=1: simultaneous unload and load, occ unchanged.
REQ-023 Flush SHALL clear all valid bits at the next edge; input that cycle is not accepted; output handshake that cycle still completes at the downstream side; data registers not cleared.
REQ-024 occ SHALL equal the population count of valid bits, updated same edge as the bits.

Reset
REQ-025 rst high SHALL immediately clear all valid bits, data registers to 0, occ to 0, out_valid to 0, regardless of clk.
REQ-026 Reset mid-transfer SHALL discard all payloads; first accept after rst release is on the first rising edge with in_valid && in_ready.
REQ-027 in_ready SHALL be 1 while in reset with flush=0 (stage 0 empty).

Configuration
REQ-028 Macro PIPE_STAGE_STALL_CNT_EN defined: adds output stall_cnt, 16 bits, incremented each cycle out_valid && !out_ready, saturating at 16'hFFFF.
REQ-029 With PIPE_STAGE_STALL_CNT_EN: stall_cnt reset to 0 by rst only; flush does not clear it.
REQ-030 Without PIPE_STAGE_STALL_CNT_EN: port stall_cnt and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 DEPTH=1, out_ready=1, in_data=0x12345678_9ABCDEF0 pattern each cycle for 8 cycles -> each value on out_data 1 cycle later, out_valid=1 continuous, occ=1.
REQ-032 DEPTH=3, push A,B,C with out_ready=0 -> occ=3, in_ready=0, out_data=A held; raise out_ready 3 cycles -> A,B,C in order, occ 3,2,1,0.
REQ-033 DEPTH=2, full, in_valid=1 and out_ready=1 same cycle -> occ stays 2, new payload appears out 2 cycles later.
REQ-034 DEPTH=4, 3 payloads in flight, flush for 1 cycle with in_valid=1 -> in_ready=0 that cycle, next edge occ=0, out_valid=0, flushed input never emerges.
REQ-035 Assert rst asynchronously mid-clock with occ=2 -> out_valid, occ, out_data go 0 before next edge; normal acceptance after release.
REQ-036 With PIPE_STAGE_STALL_CNT_EN, hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF, no wrap; flush leaves it unchanged.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage valid/ready register pipeline with flush, async reset and occupancy count.
// Optional 16-bit saturating output-stall counter when PIPE_STAGE_STALL_CNT_EN is defined.
module pipe_stage_reg #(
   parameter int DATA_W = 71,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [2:0]        occ
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,output logic [15:0]       stall_cnt
`endif
);

   generate
      if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
         $error("pipe_stage_reg: DEPTH must be in 1..4");
      end
   endgenerate

   logic [DEPTH-1:0]  r_valid;
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [2:0]        r_occ;

   logic [DEPTH-1:0]  w_load;
   logic [DEPTH-1:0]  w_cap;
   logic [DEPTH-1:0]  w_valid_nxt;
   logic [2:0]        w_occ_nxt;

   // Ready chain: a stage may load when empty or when the stage ahead loads this cycle.
   always_comb begin
      logic w_l;
      w_l = !r_valid[DEPTH-1] || out_ready;
      w_load = '0;
      w_load[DEPTH-1] = w_l;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         w_l = !r_valid[k] || w_l;
         w_load[k] = w_l;
      end
   end

   assign in_ready = w_load[0] && !flush;

   always_comb begin
      w_valid_nxt = '0;
      w_cap       = '0;
      w_occ_nxt   = '0;
      if (!flush) begin
         w_valid_nxt[0] = w_load[0] ? in_valid : r_valid[0];
         w_cap[0]       = in_valid && w_load[0];
         for (int k = 1; k < DEPTH; k++) begin
            w_valid_nxt[k] = w_load[k] ? r_valid[k-1] : r_valid[k];
            // Bubbles are not copied so idle data registers keep their last payload.
            w_cap[k]       = w_load[k] && r_valid[k-1];
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         w_occ_nxt = w_occ_nxt + 3'(w_valid_nxt[k]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_occ   <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         r_valid <= w_valid_nxt;
         r_occ   <= w_occ_nxt;
         if (w_cap[0]) begin
            r_data[0] <= in_data;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (w_cap[k]) begin
               r_data[k] <= r_data[k-1];
            end
         end
      end
   end

   assign out_valid = r_valid[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];
   assign occ       = r_occ;

`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (r_valid[DEPTH-1] && !out_ready && r_stall_cnt != 16'hFFFF) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   // No stall counter in this build.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Random-stimulus bench for pipe_stage_reg at DEPTH 1..4 against a queue-of-positions model.
module tb_pipe_stage_reg;
   localparam int W = 71;
   localparam int RST_A = 150;
   localparam int RST_B = 550;
   localparam int N_RAND = 1600;
`ifdef PIPE_STAGE_STALL_CNT_EN
   localparam int STALL_START = N_RAND;
   localparam int N_CYC = N_RAND + 70000 + 20;
`else
   localparam int N_CYC = N_RAND;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [3:0]   t_in_valid, t_out_ready, t_flush;
   logic [3:0]   w_in_ready, w_out_valid;
   logic [W-1:0] t_in_data  [4];
   logic [W-1:0] w_out_data [4];
   logic [2:0]   w_occ      [4];
`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [15:0]  w_stall    [4];
`endif

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_dut
         pipe_stage_reg #(.DATA_W(W), .DEPTH(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (t_in_valid[g]),
            .in_ready  (w_in_ready[g]),
            .in_data   (t_in_data[g]),
            .flush     (t_flush[g]),
            .out_valid (w_out_valid[g]),
            .out_ready (t_out_ready[g]),
            .out_data  (w_out_data[g]),
            .occ       (w_occ[g])
`ifdef PIPE_STAGE_STALL_CNT_EN
           ,.stall_cnt (w_stall[g])
`endif
         );
      end
   endgenerate

   // Model: per instance, items oldest-first with their stage position.
   logic [W-1:0] m_dat [4][4];
   int           m_pos [4][4];
   int           m_n   [4];
   logic [W-1:0] m_last[4];
   logic [W-1:0] x_dat [4][4];
   int           x_pos [4][4];
   int           x_n   [4];
   logic [W-1:0] x_last[4];
`ifdef PIPE_STAGE_STALL_CNT_EN
   int           m_stall[4];
   int           x_stall[4];
`endif

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_n[i]    = 0;
         m_last[i] = '0;
`ifdef PIPE_STAGE_STALL_CNT_EN
         m_stall[i] = 0;
`endif
      end
   endtask

   // Each item moves one stage forward when the slot ahead is free at the end of the cycle.
   task automatic model_step(input int i, output logic exp_rdy);
      int d;
      int a;
      int nn;
      int p;
      int np;
      d  = i + 1;
      a  = d;
      nn = 0;
      x_last[i] = m_last[i];
`ifdef PIPE_STAGE_STALL_CNT_EN
      x_stall[i] = m_stall[i];
      if (m_n[i] > 0 && m_pos[i][0] == d - 1 && !t_out_ready[i] && x_stall[i] < 65535)
         x_stall[i]++;
`endif
      for (int j = 0; j < m_n[i]; j++) begin
         p = m_pos[i][j];
         if (!(j == 0 && p == d - 1 && t_out_ready[i])) begin
            np = (a > p + 1) ? p + 1 : p;
            x_dat[i][nn] = m_dat[i][j];
            x_pos[i][nn] = np;
            nn++;
            a = np;
            if (np == d - 1 && p != d - 1 && !t_flush[i]) x_last[i] = m_dat[i][j];
         end
      end
      exp_rdy = !t_flush[i] && (a > 0);
      if (exp_rdy && t_in_valid[i]) begin
         x_dat[i][nn] = t_in_data[i];
         x_pos[i][nn] = 0;
         nn++;
         if (d == 1) x_last[i] = t_in_data[i];
      end
      if (t_flush[i]) nn = 0;
      x_n[i] = nn;
   endtask

   task automatic drive(input int c);
      int mode;
      mode = (c / 100) % 4;
      for (int i = 0; i < 4; i++) begin
         case (mode)
            0: begin t_in_valid[i] = 1'b1; t_out_ready[i] = 1'b1; t_flush[i] = 1'b0; end
            1: begin
               t_in_valid[i]  = ($urandom_range(0, 3) != 0);
               t_out_ready[i] = ($urandom_range(0, 4) == 0);
               t_flush[i]     = 1'b0;
            end
            2: begin
               t_in_valid[i]  = 1'($urandom_range(0, 1));
               t_out_ready[i] = 1'($urandom_range(0, 1));
               t_flush[i]     = ($urandom_range(0, 15) == 0);
            end
            default: begin
               t_in_valid[i]  = 1'($urandom_range(0, 1));
               t_out_ready[i] = 1'b1;
               t_flush[i]     = ($urandom_range(0, 31) == 0);
            end
         endcase
`ifdef PIPE_STAGE_STALL_CNT_EN
         if (c >= STALL_START && c <= STALL_START + 70000) begin
            t_in_valid[i]  = 1'b1;
            t_out_ready[i] = 1'b0;
            t_flush[i]     = (c == STALL_START + 70000);
         end
`endif
         t_in_data[i] = {7'($urandom), $urandom, $urandom};
      end
   endtask

   initial begin
      logic er;
      rst         = 1'b1;
      t_in_valid  = '0;
      t_out_ready = '0;
      t_flush     = '0;
      for (int i = 0; i < 4; i++) t_in_data[i] = '0;
      model_clear();

      #3;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("d%0d.rst_oval", i + 1), 72'(w_out_valid[i]), 72'(0));
         chk($sformatf("d%0d.rst_occ", i + 1), 72'(w_occ[i]), 72'(0));
         chk($sformatf("d%0d.rst_odat", i + 1), 72'(w_out_data[i]), 72'(0));
         chk($sformatf("d%0d.rst_irdy", i + 1), 72'(w_in_ready[i]), 72'(1));
      end
      @(posedge clk);
      #1 rst = 1'b0;
      drive(0);

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            model_step(i, er);
            chk($sformatf("d%0d.oval", i + 1), 72'(w_out_valid[i]),
                72'(m_n[i] > 0 && m_pos[i][0] == i));
            chk($sformatf("d%0d.occ", i + 1), 72'(w_occ[i]), 72'(m_n[i]));
            chk($sformatf("d%0d.odat", i + 1), 72'(w_out_data[i]), 72'(m_last[i]));
            chk($sformatf("d%0d.irdy", i + 1), 72'(w_in_ready[i]), 72'(er));
`ifdef PIPE_STAGE_STALL_CNT_EN
            chk($sformatf("d%0d.stall", i + 1), 72'(w_stall[i]), 72'(m_stall[i]));
`endif
         end
`ifdef PIPE_STAGE_STALL_CNT_EN
         if (cyc == STALL_START + 70000 || cyc == STALL_START + 70002)
            chk("stall_sat", 72'(w_stall[0]), 72'(16'hFFFF));
`endif
         if (cyc == RST_A || cyc == RST_B) begin
            #1 rst = 1'b1;
            #1;
            for (int i = 0; i < 4; i++) begin
               chk($sformatf("d%0d.arst_oval", i + 1), 72'(w_out_valid[i]), 72'(0));
               chk($sformatf("d%0d.arst_occ", i + 1), 72'(w_occ[i]), 72'(0));
               chk($sformatf("d%0d.arst_odat", i + 1), 72'(w_out_data[i]), 72'(0));
               chk($sformatf("d%0d.arst_irdy", i + 1), 72'(w_in_ready[i]), 72'(!t_flush[i]));
            end
            model_clear();
            @(posedge clk);
            #1 rst = 1'b0;
         end else begin
            @(posedge clk);
            #1;
            m_dat  = x_dat;
            m_pos  = x_pos;
            m_n    = x_n;
            m_last = x_last;
`ifdef PIPE_STAGE_STALL_CNT_EN
            m_stall = x_stall;
`endif
         end
         drive(cyc + 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
